msrv32_ahb_data_bridge: RTL and testbench

- AHB-Lite master bridge that sits directly downstream of the core's data-memory port.
- Consumes the core's data-side request (address, write data, write request, byte mask, htrans) and drives a pipelined AHB-Lite data bus.
- Returns ready, read data and error response to the core's load unit and machine-control logic.
- Adds byte-lane/HSIZE encoding, error-response cancellation and a bus-hang watchdog.

---
 rtl/msrv32_ahb_pkg.sv | 27 ++
 rtl/msrv32_ahb_size_enc.sv | 35 +++
 rtl/msrv32_ahb_data_bridge.sv | 142 ++++++++++++++
 tb/tb_msrv32_ahb_data_bridge.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_ahb_pkg.sv
// Shared AHB-Lite constants, bridge state encoding and address-phase payload
// for the msrv32 data-side bridge.
package msrv32_ahb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR  = 2'b10
  } bridge_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
  } ahb_addr_phase_t;

endpackage

// File: rtl/msrv32_ahb_size_enc.sv
// Maps a store byte-lane mask to HSIZE and the low address bits; loads are
// always word transfers on an aligned address.
module msrv32_ahb_size_enc
  import msrv32_ahb_pkg::*;
(
  input  logic              wr,
  input  logic [3:0]        mask,
  input  logic [29:0]       addr_hi,
  output logic [ADDR_W-1:0] haddr,
  output logic [2:0]        hsize,
  output logic              illegal
);

  logic [1:0] lo;

  always_comb begin
    hsize   = HSIZE_WORD;
    lo      = 2'b00;
    illegal = 1'b0;
    if (wr) begin
      case (mask)
        4'b1111: begin hsize = HSIZE_WORD; lo = 2'b00; end
        4'b0011: begin hsize = HSIZE_HALF; lo = 2'b00; end
        4'b1100: begin hsize = HSIZE_HALF; lo = 2'b10; end
        4'b0001: begin hsize = HSIZE_BYTE; lo = 2'b00; end
        4'b0010: begin hsize = HSIZE_BYTE; lo = 2'b01; end
        4'b0100: begin hsize = HSIZE_BYTE; lo = 2'b10; end
        4'b1000: begin hsize = HSIZE_BYTE; lo = 2'b11; end
        default: illegal = 1'b1;
      endcase
    end
    haddr = {addr_hi, lo};
  end

endmodule

// File: rtl/msrv32_ahb_data_bridge.sv
// Core data-port to AHB-Lite master bridge: combinational address phase,
// registered write data, ERROR cancellation and a bus-hang watchdog.
module msrv32_ahb_data_bridge
  import msrv32_ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_CNT_W       = 9
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic [1:0]        core_htrans_in,
  input  logic [ADDR_W-1:0] core_addr_in,
  input  logic [DATA_W-1:0] core_wdata_in,
  input  logic              core_wr_req_in,
  input  logic [3:0]        core_wr_mask_in,
  output logic              core_hready_out,
  output logic [DATA_W-1:0] core_rdata_out,
  output logic              core_hresp_out,
  output logic [ADDR_W-1:0] haddr_out,
  output logic              hwrite_out,
  output logic [2:0]        hsize_out,
  output logic [1:0]        htrans_out,
  output logic [DATA_W-1:0] hwdata_out,
  input  logic [DATA_W-1:0] hrdata_in,
  input  logic              hready_in,
  input  logic              hresp_in,
  output logic              bus_timeout_out
);

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_CNT_W-1:0] WD_LAST =
    TO_CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic clk;
  logic rst_n;
  assign clk   = ms_riscv32_mp_clk_in;
  assign rst_n = ms_riscv32_mp_rst_in;

  bridge_state_t       state_q, state_d;
  logic                err_pend_q, err_pend_d;
  logic [TO_CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [DATA_W-1:0]   hwdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic              accept, issue, wd_fire, data_done, illegal;
  logic [ADDR_W-1:0] enc_haddr;
  logic [2:0]        enc_hsize;
  ahb_addr_phase_t   ap;

  msrv32_ahb_size_enc u_size_enc (
    .wr      (core_wr_req_in),
    .mask    (core_wr_mask_in),
    .addr_hi (core_addr_in[31:2]),
    .haddr   (enc_haddr),
    .hsize   (enc_hsize),
    .illegal (illegal)
  );

  // Next-state, core response and watchdog control
  always_comb begin
    state_d         = state_q;
    err_pend_d      = 1'b0;
    wd_cnt_d        = '0;
    core_hready_out = 1'b1;
    core_hresp_out  = 1'b0;
    bus_timeout_out = 1'b0;

    data_done = (state_q == ST_DATA) && hready_in;
    wd_fire   = WD_EN && (state_q == ST_DATA) && !hready_in && (wd_cnt_q == WD_LAST);
    // Reset gates acceptance so the address phase drops immediately on rst_n
    accept    = rst_n && (core_htrans_in == HTRANS_NONSEQ) &&
                ((state_q == ST_IDLE) || (data_done && !hresp_in));
    issue     = accept && !illegal;

    case (state_q)
      ST_IDLE: begin
        core_hresp_out = err_pend_q;
        if (issue) state_d = ST_DATA;
      end
      ST_DATA: begin
        core_hready_out = hready_in;
        if (wd_fire) begin
          core_hready_out = 1'b1;
          core_hresp_out  = 1'b1;
          bus_timeout_out = 1'b1;
          state_d         = ST_IDLE;
        end else if (hready_in) begin
          core_hresp_out = hresp_in;
          state_d        = issue ? ST_DATA : ST_IDLE;
        end else if (hresp_in) begin
          state_d = ST_ERR;
        end else if (WD_EN) begin
          wd_cnt_d = wd_cnt_q + TO_CNT_W'(1);
        end
      end
      ST_ERR: begin
        core_hready_out = hready_in;
        core_hresp_out  = hready_in;
        if (hready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_pend_d = accept && illegal;
  end

  // Address phase is driven only in the cycle a transfer is issued
  always_comb begin
    ap.haddr  = '0;
    ap.hwrite = 1'b0;
    ap.hsize  = HSIZE_WORD;
    if (issue) begin
      ap.haddr  = enc_haddr;
      ap.hwrite = core_wr_req_in;
      ap.hsize  = enc_hsize;
    end
  end

  assign htrans_out     = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_out      = ap.haddr;
  assign hwrite_out     = ap.hwrite;
  assign hsize_out      = ap.hsize;
  assign hwdata_out     = hwdata_q;
  assign core_rdata_out = data_done ? hrdata_in : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      err_pend_q <= 1'b0;
      wd_cnt_q   <= '0;
      hwdata_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      err_pend_q <= err_pend_d;
      wd_cnt_q   <= wd_cnt_d;
      if (issue)     hwdata_q <= core_wdata_in;
      if (data_done) rdata_q  <= hrdata_in;
    end
  end

endmodule

// File: tb/tb_msrv32_ahb_data_bridge.sv
// Directed self-checking bench for msrv32_ahb_data_bridge (watchdog set to 4 cycles).
module tb_msrv32_ahb_data_bridge;

  logic        clk;
  logic        rst_n;
  logic [1:0]  core_htrans_in;
  logic [31:0] core_addr_in;
  logic [31:0] core_wdata_in;
  logic        core_wr_req_in;
  logic [3:0]  core_wr_mask_in;
  logic        core_hready_out;
  logic [31:0] core_rdata_out;
  logic        core_hresp_out;
  logic [31:0] haddr_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [1:0]  htrans_out;
  logic [31:0] hwdata_out;
  logic [31:0] hrdata_in;
  logic        hready_in;
  logic        hresp_in;
  logic        bus_timeout_out;

  int n_chk;
  int n_fail;

  localparam logic [104:0] RST_VEC = {2'b00, 32'h0, 1'b0, 3'b010, 32'h0,
                                      1'b1, 1'b0, 32'h0, 1'b0};
  logic [104:0] out_vec;
  assign out_vec = {htrans_out, haddr_out, hwrite_out, hsize_out, hwdata_out,
                    core_hready_out, core_hresp_out, core_rdata_out, bus_timeout_out};

  msrv32_ahb_data_bridge #(.TIMEOUT_CYCLES(4), .TO_CNT_W(3)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .core_htrans_in       (core_htrans_in),
    .core_addr_in         (core_addr_in),
    .core_wdata_in        (core_wdata_in),
    .core_wr_req_in       (core_wr_req_in),
    .core_wr_mask_in      (core_wr_mask_in),
    .core_hready_out      (core_hready_out),
    .core_rdata_out       (core_rdata_out),
    .core_hresp_out       (core_hresp_out),
    .haddr_out            (haddr_out),
    .hwrite_out           (hwrite_out),
    .hsize_out            (hsize_out),
    .htrans_out           (htrans_out),
    .hwdata_out           (hwdata_out),
    .hrdata_in            (hrdata_in),
    .hready_in            (hready_in),
    .hresp_in             (hresp_in),
    .bus_timeout_out      (bus_timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic wr, input logic [3:0] m,
                     input logic [31:0] d);
    core_htrans_in  = 2'b10;
    core_addr_in    = a;
    core_wr_req_in  = wr;
    core_wr_mask_in = m;
    core_wdata_in   = d;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if (out_vec !== RST_VEC) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", out_vec, RST_VEC);
    end
  endtask

  task automatic test_word_store();
    cyc(); req(32'h1000_0004, 1'b1, 4'b1111, 32'hDEAD_BEEF); hready_in = 1'b1; #1;
    n_chk++;
    if ({htrans_out, haddr_out, hwrite_out, hsize_out} !== {2'b10, 32'h1000_0004, 1'b1, 3'b010}) begin
      n_fail++; $display("FAIL word_store_addr_phase: got %h expected %h",
        {htrans_out, haddr_out, hwrite_out, hsize_out}, {2'b10, 32'h1000_0004, 1'b1, 3'b010});
    end
    cyc(); core_htrans_in = 2'b00; #1;
    n_chk++;
    if ({hwdata_out, core_hready_out, core_hresp_out, htrans_out} !== {32'hDEAD_BEEF, 1'b1, 1'b0, 2'b00}) begin
      n_fail++; $display("FAIL word_store_data_phase: got %h expected %h",
        {hwdata_out, core_hready_out, core_hresp_out, htrans_out}, {32'hDEAD_BEEF, 1'b1, 1'b0, 2'b00});
    end
  endtask

  task automatic test_byte_half_illegal();
    cyc(); req(32'h2000_0000, 1'b1, 4'b0100, 32'h00AB_0000); #1;
    n_chk++;
    if ({htrans_out, haddr_out, hsize_out} !== {2'b10, 32'h2000_0002, 3'b000}) begin
      n_fail++; $display("FAIL byte_store_encode: got %h expected %h",
        {htrans_out, haddr_out, hsize_out}, {2'b10, 32'h2000_0002, 3'b000});
    end
    cyc(); req(32'h3000_0000, 1'b1, 4'b1100, 32'h5A5A_0000); #1;
    n_chk++;
    if ({htrans_out, haddr_out, hsize_out, hwdata_out} !== {2'b10, 32'h3000_0002, 3'b001, 32'h00AB_0000}) begin
      n_fail++; $display("FAIL half_store_b2b: got %h expected %h",
        {htrans_out, haddr_out, hsize_out, hwdata_out}, {2'b10, 32'h3000_0002, 3'b001, 32'h00AB_0000});
    end
    cyc(); req(32'h3000_0000, 1'b1, 4'b0110, 32'h1111_1111); #1;
    n_chk++;
    if ({htrans_out, core_hready_out, core_hresp_out, hwdata_out} !== {2'b00, 1'b1, 1'b0, 32'h5A5A_0000}) begin
      n_fail++; $display("FAIL illegal_mask_no_issue: got %h expected %h",
        {htrans_out, core_hready_out, core_hresp_out, hwdata_out}, {2'b00, 1'b1, 1'b0, 32'h5A5A_0000});
    end
    cyc(); core_htrans_in = 2'b00; #1;
    n_chk++;
    if ({htrans_out, core_hready_out, core_hresp_out} !== {2'b00, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL illegal_mask_resp: got %h expected %h",
        {htrans_out, core_hready_out, core_hresp_out}, {2'b00, 1'b1, 1'b1});
    end
    cyc(); #1;
    n_chk++;
    if (core_hresp_out !== 1'b0) begin
      n_fail++; $display("FAIL illegal_mask_one_cycle: got %b expected %b", core_hresp_out, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    cyc(); req(32'h0000_0100, 1'b0, 4'b0000, 32'h0); hready_in = 1'b1; #1;
    n_chk++;
    if ({htrans_out, haddr_out, hwrite_out, hsize_out} !== {2'b10, 32'h100, 1'b0, 3'b010}) begin
      n_fail++; $display("FAIL load_a_addr_phase: got %h expected %h",
        {htrans_out, haddr_out, hwrite_out, hsize_out}, {2'b10, 32'h100, 1'b0, 3'b010});
    end
    for (int w = 0; w < 2; w++) begin
      cyc(); req(32'h0000_0104, 1'b0, 4'b0000, 32'h0); hready_in = 1'b0; #1;
      n_chk++;
      if ({htrans_out, core_hready_out} !== {2'b00, 1'b0}) begin
        n_fail++; $display("FAIL load_b_held_wait%0d: got %h expected %h",
          w, {htrans_out, core_hready_out}, {2'b00, 1'b0});
      end
    end
    cyc(); hready_in = 1'b1; hrdata_in = 32'hAAAA_0001; #1;
    n_chk++;
    if ({htrans_out, haddr_out, core_hready_out, core_rdata_out} !== {2'b10, 32'h104, 1'b1, 32'hAAAA_0001}) begin
      n_fail++; $display("FAIL load_b_issue_on_a_done: got %h expected %h",
        {htrans_out, haddr_out, core_hready_out, core_rdata_out}, {2'b10, 32'h104, 1'b1, 32'hAAAA_0001});
    end
    cyc(); core_htrans_in = 2'b00; hrdata_in = 32'hBBBB_0002; #1;
    n_chk++;
    if ({core_rdata_out, core_hready_out, core_hresp_out} !== {32'hBBBB_0002, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL load_b_data: got %h expected %h",
        {core_rdata_out, core_hready_out, core_hresp_out}, {32'hBBBB_0002, 1'b1, 1'b0});
    end
    cyc(); hrdata_in = 32'h0BAD_F00D; #1;
    n_chk++;
    if (core_rdata_out !== 32'hBBBB_0002) begin
      n_fail++; $display("FAIL rdata_hold: got %h expected %h", core_rdata_out, 32'hBBBB_0002);
    end
  endtask

  task automatic test_error();
    cyc(); req(32'h0000_0200, 1'b0, 4'b0000, 32'h0); hready_in = 1'b1; hresp_in = 1'b0; #1;
    cyc(); req(32'h0000_0300, 1'b1, 4'b1111, 32'hCAFE_0000); hready_in = 1'b0; hresp_in = 1'b1; #1;
    n_chk++;
    if ({htrans_out, core_hready_out, core_hresp_out} !== {2'b00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL error_first_cycle: got %h expected %h",
        {htrans_out, core_hready_out, core_hresp_out}, {2'b00, 1'b0, 1'b0});
    end
    cyc(); hready_in = 1'b1; hresp_in = 1'b1; #1;
    n_chk++;
    if ({htrans_out, core_hready_out, core_hresp_out} !== {2'b00, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL error_second_cycle: got %h expected %h",
        {htrans_out, core_hready_out, core_hresp_out}, {2'b00, 1'b1, 1'b1});
    end
    cyc(); req(32'h0000_0400, 1'b0, 4'b0000, 32'h0); hresp_in = 1'b0; #1;
    n_chk++;
    if ({htrans_out, haddr_out, core_hready_out, core_hresp_out} !== {2'b10, 32'h400, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL error_back_to_idle: got %h expected %h",
        {htrans_out, haddr_out, core_hready_out, core_hresp_out}, {2'b10, 32'h400, 1'b1, 1'b0});
    end
    cyc(); core_htrans_in = 2'b00; #1;
  endtask

  task automatic test_timeout();
    logic exp_to;
    cyc(); req(32'h0000_0500, 1'b0, 4'b0000, 32'h0); hready_in = 1'b1; #1;
    for (int w = 1; w <= 4; w++) begin
      cyc(); req(32'h0000_0600, 1'b0, 4'b0000, 32'h0); hready_in = 1'b0; #1;
      exp_to = (w == 4);
      n_chk++;
      if ({bus_timeout_out, core_hready_out, core_hresp_out, htrans_out} !== {exp_to, exp_to, exp_to, 2'b00}) begin
        n_fail++; $display("FAIL timeout_wait%0d: got %h expected %h", w,
          {bus_timeout_out, core_hready_out, core_hresp_out, htrans_out}, {exp_to, exp_to, exp_to, 2'b00});
      end
    end
    cyc(); hready_in = 1'b1; #1;
    n_chk++;
    if ({htrans_out, haddr_out, bus_timeout_out, core_hresp_out} !== {2'b10, 32'h600, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL timeout_recover_issue: got %h expected %h",
        {htrans_out, haddr_out, bus_timeout_out, core_hresp_out}, {2'b10, 32'h600, 1'b0, 1'b0});
    end
    cyc(); core_htrans_in = 2'b00; hrdata_in = 32'h0000_0066; #1;
    n_chk++;
    if ({core_rdata_out, core_hready_out, core_hresp_out} !== {32'h66, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL timeout_recover_data: got %h expected %h",
        {core_rdata_out, core_hready_out, core_hresp_out}, {32'h66, 1'b1, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    cyc(); req(32'h0000_0700, 1'b1, 4'b1111, 32'h1234_5678); hready_in = 1'b1; #1;
    cyc(); req(32'h0000_0704, 1'b1, 4'b1111, 32'h0); hready_in = 1'b0; #1;
    n_chk++;
    if ({hwdata_out, htrans_out} !== {32'h1234_5678, 2'b00}) begin
      n_fail++; $display("FAIL mid_data_phase: got %h expected %h",
        {hwdata_out, htrans_out}, {32'h1234_5678, 2'b00});
    end
    #2; rst_n = 1'b0; #1;
    n_chk++;
    if (out_vec !== RST_VEC) begin
      n_fail++; $display("FAIL async_reset_values: got %h expected %h", out_vec, RST_VEC);
    end
    cyc(); #1;
    n_chk++;
    if (out_vec !== RST_VEC) begin
      n_fail++; $display("FAIL held_reset_values: got %h expected %h", out_vec, RST_VEC);
    end
    cyc(); rst_n = 1'b1; req(32'h0000_0800, 1'b0, 4'b0000, 32'h0); hready_in = 1'b1; #1;
    n_chk++;
    if ({htrans_out, haddr_out, hwrite_out} !== {2'b10, 32'h800, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_issue: got %h expected %h",
        {htrans_out, haddr_out, hwrite_out}, {2'b10, 32'h800, 1'b0});
    end
    cyc(); core_htrans_in = 2'b00; hrdata_in = 32'h0000_0088; #1;
    n_chk++;
    if ({core_rdata_out, core_hready_out, core_hresp_out} !== {32'h88, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_data: got %h expected %h",
        {core_rdata_out, core_hready_out, core_hresp_out}, {32'h88, 1'b1, 1'b0});
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    core_htrans_in = 2'b00;
    core_addr_in = '0;
    core_wdata_in = '0;
    core_wr_req_in = 1'b0;
    core_wr_mask_in = 4'b0000;
    hrdata_in = '0;
    hready_in = 1'b1;
    hresp_in = 1'b0;
    cyc();
    test_reset();
    cyc();
    rst_n = 1'b1;
    test_word_store();
    test_byte_half_illegal();
    test_back_to_back();
    test_error();
    test_timeout();
    test_reset_mid();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
